// File: rtl/rca_pkg.sv
// Shared constants and mode encoding for the pipelined ripple-carry adder.
package rca_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 16;
  localparam int unsigned DEFAULT_STAGES = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build each ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_pipe.sv
// Ripple-carry adder/subtractor split into STAGES slices with a skid-free
// stall-on-backpressure pipeline; operand upper bits ride along in skew buffers.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CH   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("rca_pipe: WIDTH must be >= 2 and divisible by STAGES");
  end

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             advance;

  // Subtract folds into the add path: invert B and the carry-in at entry.
  always_comb begin
    b_eff = b_in;
    c_eff = c_in;
    if (mode_e'(sub) == MODE_SUB) begin
      b_eff = ~b_in;
      c_eff = ~c_in;
    end
  end

  assign advance  = !out_valid || out_ready;
  assign in_ready = rst || advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned DONE = (k + 1) * CH;

    logic [CH-1:0]   x_c;
    logic [CH-1:0]   y_c;
    logic [CH-1:0]   sum_c;
    logic [CH:0]     chain_c;
    logic [DONE-1:0] sum_n;
    logic [DONE-1:0] sum_r;
    logic            valid_n;
    logic            valid_r;
    logic            carry_r;

    // Slice operands come from the ports for stage 0, else from the previous skew buffer.
    if (k == 0) begin : g_src
      assign x_c        = a_in[CH-1:0];
      assign y_c        = b_eff[CH-1:0];
      assign chain_c[0] = c_eff;
      assign valid_n    = in_valid;
      assign sum_n      = sum_c;
    end else begin : g_src
      assign x_c        = g_stage[k-1].g_skew.a_r[CH-1:0];
      assign y_c        = g_stage[k-1].g_skew.b_r[CH-1:0];
      assign chain_c[0] = g_stage[k-1].carry_r;
      assign valid_n    = g_stage[k-1].valid_r;
      assign sum_n      = {sum_c, g_stage[k-1].sum_r};
    end

    for (genvar i = 0; i < CH; i++) begin : g_bit
      full_adder u_fa (
        .a    (x_c[i]),
        .b    (y_c[i]),
        .cin  (chain_c[i]),
        .sum  (sum_c[i]),
        .cout (chain_c[i+1])
      );
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= '0;
      end else if (advance) begin
        valid_r <= valid_n;
        carry_r <= chain_c[CH];
        sum_r   <= sum_n;
      end
    end

    // Skew buffer: operand bits not yet added, shifted so the next slice sits at bit 0.
    if (k < LAST) begin : g_skew
      localparam int unsigned REM = WIDTH - DONE;

      logic [REM-1:0] a_n;
      logic [REM-1:0] b_n;
      logic [REM-1:0] a_r;
      logic [REM-1:0] b_r;

      if (k == 0) begin : g_sel
        assign a_n = a_in[WIDTH-1:CH];
        assign b_n = b_eff[WIDTH-1:CH];
      end else begin : g_sel
        assign a_n = g_stage[k-1].g_skew.a_r[REM+CH-1:CH];
        assign b_n = g_stage[k-1].g_skew.b_r[REM+CH-1:CH];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (advance) begin
          a_r <= a_n;
          b_r <= b_n;
        end
      end
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    if (k == LAST) begin : g_last
      logic ovf_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (advance) begin
          ovf_r <= chain_c[CH] ^ chain_c[CH-1];
        end
      end
    end
  end

  assign s         = g_stage[LAST].sum_r;
  assign cout      = g_stage[LAST].carry_r;
  assign ovf       = g_stage[LAST].g_last.ovf_r;
  assign out_valid = g_stage[LAST].valid_r;

endmodule

// File: tb/tb_rca_pipe.sv
// Scoreboard bench for rca_pipe: directed corner beats, stall, reset flush and random traffic.
module tb_rca_pipe;

  parameter int unsigned WIDTH  = 16;
  parameter int unsigned STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  rca_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    int               acc_cyc;
    bit               lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer arithmetic on the operands.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic m);
    exp_t   e;
    longint ua, ub, sa, sb, r, sr, hi, lo;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lo = -(longint'(1) << (WIDTH - 1));
    if (m) begin
      r      = ua - ub - longint'(c);
      sr     = sa - sb - longint'(c);
      e.cout = (r >= 0);
    end else begin
      r      = ua + ub + longint'(c);
      sr     = sa + sb + longint'(c);
      e.cout = (r >= (longint'(1) << WIDTH));
    end
    e.s       = WIDTH'(r);
    e.ovf     = (sr > hi) || (sr < lo);
    e.acc_cyc = 0;
    e.lat     = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One cycle of stimulus; pushes the expected result if the beat is accepted.
  task automatic step(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input bit c, input bit m, input bit ordy, input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    a_in      = a;
    b_in      = b;
    c_in      = c;
    sub       = m;
    out_ready = ordy;
    #4;
    acc = v && in_ready && !rst;
    if (acc) begin
      e         = model(a, b, c, m);
      e.acc_cyc = cyc;
      e.lat     = lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    bit acc;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, acc);
      n++;
    end
    #1;
    check("drain_empty", longint'(exp_q.size()), 0);
  endtask

  task automatic beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input bit c, input bit m);
    bit acc;
    step(1'b1, a, b, c, m, 1'b1, 1'b1, acc);
    check("beat_accepted", longint'(acc), 1);
    drain(STAGES + 20);
  endtask

  // Monitor: handshake rule, stall stability and in-order result checking.
  logic             held = 1'b0;
  logic [WIDTH-1:0] held_s;
  logic             held_cout;
  logic             held_ovf;

  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (rst) begin
      held = 1'b0;
    end else begin
      check("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
      if (held) begin
        check("stall_valid", longint'(out_valid), 1);
        check("stall_s", longint'(s), longint'(held_s));
        check("stall_cout_ovf", longint'({cout, ovf}), longint'({held_cout, held_ovf}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", longint'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("s", longint'(s), longint'(e.s));
          check("cout", longint'(cout), longint'(e.cout));
          check("ovf", longint'(ovf), longint'(e.ovf));
          if (e.lat) check("latency", longint'(cyc - e.acc_cyc), longint'(STAGES));
        end
      end
      held      = out_valid && !out_ready;
      held_s    = s;
      held_cout = cout;
      held_ovf  = ovf;
    end
  end

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    int i;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_s", longint'(s), 0);
    check("rst_cout_ovf", longint'({cout, ovf}), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner beats.
    beat(WIDTH'(16'h0005), WIDTH'(16'h0000), 1'b0, 1'b0);
    beat(WIDTH'(16'hFFFF), WIDTH'(16'h0001), 1'b0, 1'b0);
    beat(WIDTH'(16'h7FFF), WIDTH'(16'h0001), 1'b0, 1'b0);
    beat(WIDTH'(16'h0005), WIDTH'(16'h0007), 1'b0, 1'b1);
    beat(WIDTH'(16'h8000), WIDTH'(16'h0001), 1'b0, 1'b1);
    beat(WIDTH'(16'h1234), WIDTH'(16'h1234), 1'b1, 1'b1);
    beat(WIDTH'(16'hFFFF), WIDTH'(16'hFFFF), 1'b1, 1'b0);

    // Eight back-to-back beats with a three-cycle consumer stall mid-stream.
    n = 0;
    i = 0;
    while (n < 8 && i < 200) begin
      step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
           !(i >= 5 && i < 8), 1'b0, acc);
      if (acc) n++;
      i++;
    end
    check("stream_accepted", longint'(n), 8);
    drain(STAGES + 40);

    // Reset with beats in flight: everything is discarded.
    for (int j = 0; j < 3; j++) begin
      step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, acc);
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    a_in     = WIDTH'($urandom);
    exp_q.delete();
    #4;
    check("rst_mid_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", longint'(out_valid), 0);
    check("rst_mid_s", longint'(s), 0);
    check("rst_mid_cout_ovf", longint'({cout, ovf}), 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int j = 0; j < int'(STAGES) + 3; j++) begin
      step(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, acc);
    end
    beat(WIDTH'(16'h00A5), WIDTH'(16'h005A), 1'b1, 1'b0);

    // Random traffic with random producer and consumer gaps.
    n = 0;
    i = 0;
    while (n < 10000 && i < 60000) begin
      step($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, 1'b0, acc);
      if (acc) n++;
      i++;
    end
    check("random_accepted", longint'(n), 10000);
    drain(STAGES + 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
